// File: rtl/diff_ext_wb_collector_pkg.sv
// Shared types and constants for the difftest writeback collector.
package diff_ext_pkg;

    // Upper bound on writeback lanes sampled per cycle.
    localparam int MAX_WB_PORTS = 8;

    // Width of per-lane slot offsets and per-cycle lane counts (0..MAX_WB_PORTS).
    localparam int WB_CNT_W = $clog2(MAX_WB_PORTS + 1);

    // Default field widths of a writeback record.
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_COREID_W = 8;
    localparam int DEF_SEQ_W    = 16;
    localparam int DEF_DROP_W   = 16;

    // One writeback record as delivered to the difftest sink (default widths).
    typedef struct packed {
        logic                    is_fp;
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_COREID_W-1:0] coreid;
        logic [DEF_SEQ_W-1:0]    seq;
    } wb_entry_t;

endpackage

// File: rtl/diff_ext_wb_collector_if.sv
// Bus bundle between the core writeback ports, the collector and the difftest sink.
//
// Output stream handshake: the collector presents an entry with out_valid=1 and holds
// every out_* field stable until the cycle in which out_ready is also 1; that cycle's
// rising edge transfers the entry. out_valid never depends on out_ready. The writeback
// lanes have no ready: lanes that find no space are dropped and counted.
interface diff_ext_wb_collector_if
    import diff_ext_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COREID_W  = DEF_COREID_W,
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = DEF_SEQ_W,
    parameter int DROP_W    = DEF_DROP_W
) ();

    logic                          enable;
    logic [NUM_PORTS-1:0]          in_valid;
    logic [NUM_PORTS-1:0]          in_is_fp;
    logic [NUM_PORTS*ADDR_W-1:0]   in_addr;
    logic [NUM_PORTS*DATA_W-1:0]   in_data;
    logic [COREID_W-1:0]           in_coreid;

    logic                          out_valid;
    logic                          out_ready;
    logic                          out_is_fp;
    logic [ADDR_W-1:0]             out_addr;
    logic [DATA_W-1:0]             out_data;
    logic [COREID_W-1:0]           out_coreid;
    logic [SEQ_W-1:0]              out_seq;

    logic [$clog2(DEPTH):0]        occupancy;
    logic [DROP_W-1:0]             drop_cnt;

    // Producer/sink side.
    modport master (
        output enable, in_valid, in_is_fp, in_addr, in_data, in_coreid, out_ready,
        input  out_valid, out_is_fp, out_addr, out_data, out_coreid, out_seq,
        input  occupancy, drop_cnt
    );

    // Collector side.
    modport slave (
        input  enable, in_valid, in_is_fp, in_addr, in_data, in_coreid, out_ready,
        output out_valid, out_is_fp, out_addr, out_data, out_coreid, out_seq,
        output occupancy, drop_cnt
    );

endinterface

// File: rtl/diff_ext_wb_collector_lane_compact.sv
// Prefix-sum over the eligible lane mask: each lane learns its slot offset among the
// eligible lanes (ascending lane order) and the total eligible count.
module wb_lane_compact
    import diff_ext_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]               elig_i,
    output logic [NUM_PORTS-1:0][WB_CNT_W-1:0] slot_o,
    output logic [WB_CNT_W-1:0]                count_o
);

    logic [WB_CNT_W-1:0] run;

    // Running count of eligible lanes below each lane index.
    always_comb begin
        run    = '0;
        slot_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            slot_o[i] = run;
            run       = run + WB_CNT_W'(elig_i[i]);
        end
        count_o = run;
    end

endmodule

// File: rtl/diff_ext_wb_collector.sv
// Difftest writeback collector: compacts up to NUM_PORTS writebacks per cycle into a
// circular FIFO, tags each with a sequence number, counts drops, and drains one entry
// per cycle to the sink.
module diff_ext_wb_collector
    import diff_ext_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COREID_W  = DEF_COREID_W,
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = DEF_SEQ_W,
    parameter int DROP_W    = DEF_DROP_W
) (
    input logic                    clock,
    input logic                    reset,
    diff_ext_wb_collector_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic                is_fp;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [COREID_W-1:0] coreid;
        logic [SEQ_W-1:0]    seq;
    } entry_t;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;

    // Payload storage; never reset, only read at occupied slots.
    entry_t ram_q [DEPTH];

    logic [NUM_PORTS-1:0]               elig;
    logic [NUM_PORTS-1:0]               lane_acc;
    logic [NUM_PORTS-1:0][WB_CNT_W-1:0] slot;
    logic [WB_CNT_W-1:0]                elig_cnt;
    logic [WB_CNT_W-1:0]                acc_cnt;
    logic [WB_CNT_W-1:0]                drop_now;
    logic [31:0]                        free_w;
    logic                               pop;
    logic [PTR_W-1:0]                   waddr [NUM_PORTS];
    entry_t                             lane_entry [NUM_PORTS];
    entry_t                             head_entry;

    assign elig = bus.in_valid & {NUM_PORTS{bus.enable}};

    wb_lane_compact #(
        .NUM_PORTS (NUM_PORTS)
    ) u_compact (
        .elig_i  (elig),
        .slot_o  (slot),
        .count_o (elig_cnt)
    );

    // Grant the lowest-offset eligible lanes up to the space free at cycle start.
    always_comb begin
        free_w   = 32'(DEPTH) - 32'(occ_q);
        lane_acc = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            lane_acc[i] = elig[i] && (32'(slot[i]) < free_w);
        end
        acc_cnt  = (32'(elig_cnt) <= free_w) ? elig_cnt : WB_CNT_W'(free_w);
        drop_now = elig_cnt - acc_cnt;
    end

    // Build each lane's record and its FIFO slot from the compacted offset.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            waddr[i]             = tail_q + PTR_W'(slot[i]);
            lane_entry[i].is_fp  = bus.in_is_fp[i];
            lane_entry[i].addr   = bus.in_addr[i*ADDR_W +: ADDR_W];
            lane_entry[i].data   = bus.in_data[i*DATA_W +: DATA_W];
            lane_entry[i].coreid = bus.in_coreid;
            lane_entry[i].seq    = seq_q + SEQ_W'(slot[i]);
        end
    end

    // Next-state for pointers and counters; a pop frees space only from the next cycle.
    always_comb begin
        pop      = (occ_q != '0) && bus.out_ready;
        head_d   = head_q + PTR_W'(pop);
        tail_d   = tail_q + PTR_W'(acc_cnt);
        occ_d    = occ_q + OCC_W'(acc_cnt) - OCC_W'(pop);
        seq_d    = seq_q + SEQ_W'(acc_cnt);
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(drop_now);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    // Control state: asynchronously cleared so no pending entry survives a reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end

    // Payload write of accepted lanes; accepted slots never overlap occupied ones.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (lane_acc[i]) begin
                ram_q[waddr[i]] <= lane_entry[i];
            end
        end
    end

    // Head presentation; fields forced to zero while empty so reset shows all-zero.
    assign head_entry     = ram_q[head_q];
    assign bus.out_valid  = (occ_q != '0);
    assign bus.out_is_fp  = bus.out_valid ? head_entry.is_fp  : 1'b0;
    assign bus.out_addr   = bus.out_valid ? head_entry.addr   : '0;
    assign bus.out_data   = bus.out_valid ? head_entry.data   : '0;
    assign bus.out_coreid = bus.out_valid ? head_entry.coreid : '0;
    assign bus.out_seq    = bus.out_valid ? head_entry.seq    : '0;
    assign bus.occupancy  = occ_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_diff_ext_wb_collector.sv
// Self-checking bench for diff_ext_wb_collector (default parameters).
module tb_diff_ext_wb_collector;

  localparam int NP    = 4;
  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int SW    = 16;
  localparam int EW    = 1 + AW + DW + CW + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  diff_ext_wb_collector_if bus ();

  diff_ext_wb_collector dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model state ----------------
  logic [EW-1:0] exp_q[$];
  int            model_occ  = 0;
  logic [SW-1:0] model_seq  = '0;
  logic [15:0]   model_drop = '0;

  // ---------------- scoreboard: compare every transferred entry ----------------
  logic [EW-1:0] sb_exp;
  logic [EW-1:0] sb_got;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      sb_got = {bus.out_is_fp, bus.out_addr, bus.out_data, bus.out_coreid, bus.out_seq};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: got entry %h but nothing expected", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          bad++;
          $display("FAIL sb_entry: got %h exp %h", sb_got, sb_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.enable    = 1'b0;
    bus.in_valid  = '0;
    bus.in_is_fp  = '0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.in_coreid = '0;
    bus.out_ready = 1'b0;
  endtask

  // Drive one cycle of stimulus (called just after a rising edge) and update the model.
  task automatic drive_cycle(input logic en, input logic [NP-1:0] v, input logic [NP-1:0] fp,
                             input logic [NP*AW-1:0] addr, input logic [NP*DW-1:0] data,
                             input logic [CW-1:0] cid, input logic rdy);
    int  free;
    int  slot;
    int  acc;
    bit  pop;
    bus.enable    = en;
    bus.in_valid  = v;
    bus.in_is_fp  = fp;
    bus.in_addr   = addr;
    bus.in_data   = data;
    bus.in_coreid = cid;
    bus.out_ready = rdy;
    free = DEPTH - model_occ;
    pop  = (model_occ != 0) && rdy;
    slot = 0;
    acc  = 0;
    for (int i = 0; i < NP; i++) begin
      if (en && v[i]) begin
        if (slot < free) begin
          exp_q.push_back({fp[i], addr[i*AW +: AW], data[i*DW +: DW], cid, model_seq});
          model_seq = model_seq + 1'b1;
          acc++;
        end else if (model_drop != 16'hFFFF) begin
          model_drop = model_drop + 1'b1;
        end
        slot++;
      end
    end
    model_occ = model_occ + acc - (pop ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic rdy);
    drive_cycle(1'b0, '0, '0, '0, '0, '0, rdy);
  endtask

  task automatic rand_cycle(input logic [NP-1:0] v, input logic rdy);
    logic [NP*AW-1:0] a;
    logic [NP*DW-1:0] d;
    for (int i = 0; i < NP; i++) begin
      a[i*AW +: AW] = AW'($urandom_range(0, 255));
      d[i*DW +: DW] = {$urandom, $urandom};
    end
    drive_cycle(1'b1, v, NP'($urandom_range(0, 15)), a, d, CW'($urandom_range(0, 255)), rdy);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    model_occ  = 0;
    model_seq  = '0;
    model_drop = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    repeat (3) idle_cycle(1'b1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", bus.out_valid); end
    total++; if (bus.occupancy !== 5'd0) begin bad++; $display("FAIL rst_occ: got %0d exp 0", bus.occupancy); end
    total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop: got %0d exp 0", bus.drop_cnt); end
    total++; if (bus.out_seq !== 16'd0) begin bad++; $display("FAIL rst_seq: got %0d exp 0", bus.out_seq); end
    total++; if (bus.out_addr !== 8'd0) begin bad++; $display("FAIL rst_addr: got %0d exp 0", bus.out_addr); end
  endtask

  task automatic test_enable_off();
    drive_cycle(1'b0, 4'b1111, 4'b0000, 32'h04030201, '1, 8'h11, 1'b1);
    total++; if (bus.occupancy !== 5'd0) begin bad++; $display("FAIL en_off_occ: got %0d exp 0", bus.occupancy); end
    total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL en_off_drop: got %0d exp 0", bus.drop_cnt); end
  endtask

  task automatic test_single();
    logic [NP*DW-1:0] d;
    d = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
         64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    drive_cycle(1'b1, 4'b1011, 4'b0010, {8'd4, 8'd3, 8'd2, 8'd1}, d, 8'h2A, 1'b1);
    total++; if (bus.occupancy !== 5'd3) begin bad++; $display("FAIL single_peak: got %0d exp 3", bus.occupancy); end
    total++; if (bus.out_addr !== 8'd1 || bus.out_seq !== 16'd0) begin
      bad++; $display("FAIL single_head0: got addr %0d seq %0d exp addr 1 seq 0", bus.out_addr, bus.out_seq); end
    idle_cycle(1'b1);
    total++; if (bus.out_addr !== 8'd2 || bus.out_seq !== 16'd1 || bus.out_is_fp !== 1'b1) begin
      bad++; $display("FAIL single_head1: got addr %0d seq %0d fp %b exp addr 2 seq 1 fp 1", bus.out_addr, bus.out_seq, bus.out_is_fp); end
    idle_cycle(1'b1);
    total++; if (bus.out_addr !== 8'd4 || bus.out_seq !== 16'd2 || bus.occupancy !== 5'd1) begin
      bad++; $display("FAIL single_head2: got addr %0d seq %0d occ %0d exp addr 4 seq 2 occ 1", bus.out_addr, bus.out_seq, bus.occupancy); end
    idle_cycle(1'b1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_empty: got valid %b exp 0", bus.out_valid); end
  endtask

  task automatic test_fill_and_full();
    int exp_occ;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      rand_cycle(4'b1111, 1'b0);
      exp_occ = (4 * k > DEPTH) ? DEPTH : 4 * k;
      total++; if (bus.occupancy !== 5'(exp_occ)) begin
        bad++; $display("FAIL fill_occ%0d: got %0d exp %0d", k, bus.occupancy, exp_occ); end
    end
    total++; if (bus.drop_cnt !== 16'd4) begin bad++; $display("FAIL fill_drop: got %0d exp 4", bus.drop_cnt); end
    // Full with a pop: no lane may take the slot freed this cycle.
    rand_cycle(4'b1111, 1'b1);
    total++; if (bus.occupancy !== 5'd15) begin bad++; $display("FAIL full_pop_occ: got %0d exp 15", bus.occupancy); end
    total++; if (bus.drop_cnt !== 16'd8) begin bad++; $display("FAIL full_pop_drop: got %0d exp 8", bus.drop_cnt); end
    total++; if (bus.out_seq !== 16'd1) begin bad++; $display("FAIL full_pop_head: got seq %0d exp 1", bus.out_seq); end
    // One slot free: only lane 0 is accepted.
    rand_cycle(4'b1111, 1'b0);
    total++; if (bus.occupancy !== 5'd16) begin bad++; $display("FAIL one_free_occ: got %0d exp 16", bus.occupancy); end
    total++; if (bus.drop_cnt !== 16'd11) begin bad++; $display("FAIL one_free_drop: got %0d exp 11", bus.drop_cnt); end
    repeat (18) idle_cycle(1'b1);
    total++; if (bus.occupancy !== 5'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL full_drain: got occ %0d pending %0d exp 0 0", bus.occupancy, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [EW:0] snap;
    logic [EW:0] prev_snap;
    bit          prev_stall;
    logic        rdy;
    prev_stall = 1'b0;
    prev_snap  = '0;
    for (int c = 0; c < 48; c++) begin
      snap = {bus.out_valid, bus.out_is_fp, bus.out_addr, bus.out_data, bus.out_coreid, bus.out_seq};
      if (prev_stall) begin
        total++;
        if (snap !== prev_snap) begin
          bad++; $display("FAIL stall_hold: cycle %0d got %h exp %h", c, snap, prev_snap);
        end
      end
      rdy        = c[0];
      prev_stall = bus.out_valid && !rdy;
      prev_snap  = snap;
      rand_cycle(NP'($urandom_range(0, 15)), rdy);
    end
    repeat (DEPTH + 2) idle_cycle(1'b1);
    total++; if (bus.occupancy !== 5'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_drain: got occ %0d pending %0d exp 0 0", bus.occupancy, exp_q.size()); end
    total++; if (bus.drop_cnt !== model_drop) begin
      bad++; $display("FAIL bp_drop: got %0d exp %0d", bus.drop_cnt, model_drop); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rand_cycle(4'b1111, 1'b0);
    rand_cycle(4'b0111, 1'b0);
    total++; if (bus.occupancy !== 5'd7) begin bad++; $display("FAIL mid_occ: got %0d exp 7", bus.occupancy); end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_occ  = 0;
    model_seq  = '0;
    model_drop = '0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 5'd0) begin
      bad++; $display("FAIL mid_async: got valid %b occ %0d exp 0 0", bus.out_valid, bus.occupancy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_cycle(1'b1, 4'b0001, 4'b0000, 32'h00000055, {192'd0, 64'h1234}, 8'h07, 1'b0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_seq !== 16'd0 || bus.out_addr !== 8'h55) begin
      bad++; $display("FAIL mid_restart: got valid %b seq %0d addr %h exp 1 0 55", bus.out_valid, bus.out_seq, bus.out_addr); end
    repeat (2) idle_cycle(1'b1);
    total++; if (bus.occupancy !== 5'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL mid_drain: got occ %0d pending %0d exp 0 0", bus.occupancy, exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_enable_off();
    test_single();
    test_fill_and_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
